// File: rtl/cpu_subsys_sram_arb.sv
// Shared single-port SRAM scratchpad with an N-requester round-robin arbiter.
// One transaction at a time: grant/access in IDLE, optional PIPE, one-cycle ready in RESP.
module cpu_subsys_sram_arb #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16384,
   parameter int NUM_PORTS = 2,
   parameter int OUT_REG   = 0,
   parameter     INIT_FILE = ""
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_PORTS-1:0]                 mem_valid,
   input  logic [NUM_PORTS-1:0][29:0]           mem_addr,
   input  logic [NUM_PORTS-1:0]                 mem_write,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]     mem_wdata,
   input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]   mem_wstrb,
   output logic [NUM_PORTS-1:0][DATA_W-1:0]     mem_rdata,
   output logic [NUM_PORTS-1:0]                 mem_ready,
   output logic [1:0]                           dbg_state
);
   localparam int NB = DATA_W / 8;
   localparam int AW = $clog2(DEPTH);
   localparam int BO = $clog2(NB);
   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

   // Handshake: a port holds valid and its request fields stable until the
   // cycle its mem_ready bit is 1; rdata is meaningful only in that cycle.
   typedef enum logic [1:0] {IDLE = 2'd0, PIPE = 2'd1, RESP = 2'd2} state_t;

   state_t            state, state_nx;
   logic [GW-1:0]     last_grant, grant_q, win;
   logic              any_valid, do_grant;
   logic [AW-1:0]     win_idx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] acc_q, rdata_q;
   logic              unused_addr;

   // Reverse scan so the last hit is the first valid port after last_grant.
   always_comb begin
      win = last_grant;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         if (mem_valid[(int'(last_grant) + k) % NUM_PORTS])
            win = GW'((int'(last_grant) + k) % NUM_PORTS);
      end
   end

   assign any_valid   = |mem_valid;
   assign do_grant    = (state == IDLE) && any_valid;
   assign win_idx     = mem_addr[win][BO +: AW];
   assign unused_addr = ^mem_addr;
   assign dbg_state   = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= LAST_PORT;
         grant_q    <= '0;
         acc_q      <= '0;
      end else begin
         state <= state_nx;
         if (do_grant) begin
            last_grant <= win;
            grant_q    <= win;
            acc_q      <= mem[win_idx];
         end
      end
   end

   // Array updates at the grant edge; acc_q above still sees the old word.
   always_ff @(posedge clk) begin
      if (do_grant && mem_write[win]) begin
         for (int b = 0; b < NB; b++) begin
            if (mem_wstrb[win][b])
               mem[win_idx][b*8 +: 8] <= mem_wdata[win][b*8 +: 8];
         end
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            rdata_q <= '0;
         else if (state == PIPE)
            rdata_q <= acc_q;
      end
   end else begin : g_noreg
      assign rdata_q = acc_q;
   end

   always_comb begin
      state_nx  = state;
      mem_ready = '0;
      case (state)
         IDLE: if (any_valid) state_nx = (OUT_REG != 0) ? PIPE : RESP;
         PIPE: state_nx = RESP;
         RESP: begin
            state_nx           = IDLE;
            mem_ready[grant_q] = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) mem_rdata[p] = rdata_q;
   end

endmodule

// File: tb/tb_cpu_subsys_sram_arb.sv
// Directed and randomised checks of cpu_subsys_sram_arb: a 4-port OUT_REG=0
// instance and a 2-port OUT_REG=1 instance, both with DEPTH=1024.
module tb_cpu_subsys_sram_arb;
   localparam int NPA = 4;
   localparam int NPB = 2;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NPA-1:0]         a_valid, a_write, a_ready;
   logic [NPA-1:0][29:0]   a_addr;
   logic [NPA-1:0][31:0]   a_wdata, a_rdata;
   logic [NPA-1:0][3:0]    a_wstrb;
   logic [1:0]             a_state;

   logic [NPB-1:0]         b_valid, b_write, b_ready;
   logic [NPB-1:0][29:0]   b_addr;
   logic [NPB-1:0][31:0]   b_wdata, b_rdata;
   logic [NPB-1:0][3:0]    b_wstrb;
   logic [1:0]             b_state;

   cpu_subsys_sram_arb #(.DATA_W(32), .DEPTH(1024), .NUM_PORTS(NPA), .OUT_REG(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .mem_valid(a_valid), .mem_addr(a_addr), .mem_write(a_write),
      .mem_wdata(a_wdata), .mem_wstrb(a_wstrb), .mem_rdata(a_rdata), .mem_ready(a_ready),
      .dbg_state(a_state));

   cpu_subsys_sram_arb #(.DATA_W(32), .DEPTH(1024), .NUM_PORTS(NPB), .OUT_REG(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .mem_valid(b_valid), .mem_addr(b_addr), .mem_write(b_write),
      .mem_wdata(b_wdata), .mem_wstrb(b_wstrb), .mem_rdata(b_rdata), .mem_ready(b_ready),
      .dbg_state(b_state));

   // scoreboard state
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model [16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // driver: one request on instance A, expects ready one edge after issue
   task automatic a_txn(input int p, input logic wr, input logic [29:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic chk_rd, input logic [31:0] exp_rd,
                        input string tag);
      int lat = 0;
      a_valid[p] = 1'b1; a_write[p] = wr; a_addr[p] = addr; a_wdata[p] = wd; a_wstrb[p] = ws;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!a_ready[p] && lat < 6);
      chk({tag, "_lat"}, 64'(lat), 64'd1);
      chk({tag, "_rdy"}, 64'(a_ready), 64'(4'b0001 << p));
      if (chk_rd) chk({tag, "_rdata"}, 64'(a_rdata[p]), 64'(exp_rd));
      @(posedge clk); #1;
      a_valid[p] = 1'b0;
      chk({tag, "_pulse"}, 64'(a_ready), 64'd0);
   endtask

   // driver: one request on instance B, expects ready two edges after issue
   task automatic b_txn(input int p, input logic wr, input logic [29:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic chk_rd, input logic [31:0] exp_rd,
                        input string tag);
      int lat = 0;
      b_valid[p] = 1'b1; b_write[p] = wr; b_addr[p] = addr; b_wdata[p] = wd; b_wstrb[p] = ws;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!b_ready[p] && lat < 6);
      chk({tag, "_lat"}, 64'(lat), 64'd2);
      chk({tag, "_rdy"}, 64'(b_ready), 64'(2'b01 << p));
      if (chk_rd) chk({tag, "_rdata"}, 64'(b_rdata[p]), 64'(exp_rd));
      @(posedge clk); #1;
      b_valid[p] = 1'b0;
      chk({tag, "_pulse"}, 64'(b_ready), 64'd0);
   endtask

   initial begin
      logic [3:0] pend, done_prev, done_now;
      int         waitc [NPA];
      int         n_issued, n_done, lat;

      rst_n   = 1'b0;
      a_valid = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
      b_valid = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_ready", a_ready, 0);
      chk("rst_a_rdata", a_rdata[0], 0);
      chk("rst_a_state", a_state, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_b_rdata", b_rdata[1], 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // OUT_REG=1 instance: two-cycle latency, then round robin at 3 cycles/txn
      b_txn(0, 1'b1, 30'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, "b_wr100");
      b_txn(0, 1'b1, 30'h104, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, "b_wr104");
      b_txn(1, 1'b0, 30'h100, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, "b_rd100");
      b_valid = 2'b11; b_write = '0; b_addr[0] = 30'h104; b_addr[1] = 30'h100;
      for (int i = 0; i < 12; i++) begin
         logic [1:0] er;
         @(posedge clk); #1;
         er = (i % 6 == 1) ? 2'b01 : (i % 6 == 4) ? 2'b10 : 2'b00;
         chk("b_rr_ready", b_ready, er);
         if (b_ready[0]) chk("b_rr_rd0", b_rdata[0], 32'hCAFEF00D);
         if (b_ready[1]) chk("b_rr_rd1", b_rdata[1], 32'hDEADBEEF);
      end
      b_valid = '0;
      @(posedge clk); #1;

      // OUT_REG=0 instance: latency, strobes, no-op write, aliasing
      a_txn(0, 1'b1, 30'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, "a_wr100");
      a_txn(0, 1'b0, 30'h100, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, "a_rd100");
      a_txn(1, 1'b1, 30'h40, 32'h11223344, 4'hF, 1'b0, 32'h0, "a_pre40");
      a_txn(1, 1'b1, 30'h40, 32'hAABBCCDD, 4'h5, 1'b1, 32'h11223344, "a_strb_old");
      a_txn(0, 1'b0, 30'h40, 32'h0, 4'h0, 1'b1, 32'h11BB33DD, "a_strb_rd");
      a_txn(1, 1'b1, 30'h40, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h11BB33DD, "a_nostrb");
      a_txn(2, 1'b0, 30'h40, 32'h0, 4'h0, 1'b1, 32'h11BB33DD, "a_nostrb_rd");
      a_txn(2, 1'b1, 30'h0, 32'h5, 4'hF, 1'b0, 32'h0, "a_wr0");
      a_txn(3, 1'b0, 30'h1000, 32'h0, 4'h0, 1'b1, 32'h5, "a_alias");
      a_txn(3, 1'b0, 30'h3, 32'h0, 4'h0, 1'b1, 32'h5, "a_lowbits");

      // two ports holding valid: 0,1,0,1 every other cycle
      a_valid = 4'b0011; a_write = '0; a_addr[0] = 30'h100; a_addr[1] = 30'h40;
      for (int i = 0; i < 8; i++) begin
         logic [3:0] er;
         @(posedge clk); #1;
         er = (i % 4 == 0) ? 4'b0001 : (i % 4 == 2) ? 4'b0010 : 4'b0000;
         chk("a_rr_ready", a_ready, er);
         if (a_ready[0]) chk("a_rr_rd0", a_rdata[0], 32'hDEADBEEF);
         if (a_ready[1]) chk("a_rr_rd1", a_rdata[1], 32'h11BB33DD);
      end
      a_valid = '0;

      // async reset in the RESP cycle of a write; request stays held
      a_valid[0] = 1'b1; a_write[0] = 1'b1; a_addr[0] = 30'h200;
      a_wdata[0] = 32'h77665544; a_wstrb[0] = 4'hF;
      @(posedge clk); #1;
      chk("a_mid_rdy", a_ready, 4'b0001);
      #2 rst_n = 1'b0;
      #1;
      chk("a_mid_rdy_drop", a_ready, 0);
      chk("a_mid_rdata", a_rdata[0], 0);
      chk("a_mid_state", a_state, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!a_ready[0] && lat < 6);
      chk("a_mid_relat", lat, 1);
      chk("a_mid_rerdy", a_ready, 4'b0001);
      @(posedge clk); #1;
      a_valid[0] = 1'b0;
      chk("a_mid_once", a_ready, 0);
      @(posedge clk); #1;
      chk("a_mid_once2", a_ready, 0);
      a_txn(1, 1'b0, 30'h200, 32'h0, 4'h0, 1'b1, 32'h77665544, "a_mid_rd");

      // stress: 4 ports, 16 words at byte 0xC00, reference model + wait bound
      for (int w = 0; w < 16; w++) begin
         logic [31:0] d;
         d = $urandom;
         model[w] = d;
         a_txn(w % 4, 1'b1, 30'hC00 | 30'(w << 2), d, 4'hF, 1'b0, 32'h0, "a_preload");
      end
      pend = '0; done_prev = '0; n_issued = 0; n_done = 0;
      for (int p = 0; p < NPA; p++) waitc[p] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         for (int p = 0; p < NPA; p++) begin
            if (done_prev[p]) begin
               pend[p] = 1'b0;
               a_valid[p] = 1'b0;
            end
         end
         chk("a_st_spurious", a_ready & ~pend, 0);
         done_now = '0;
         for (int p = 0; p < NPA; p++) begin
            if (a_ready[p] && pend[p]) begin
               int w;
               w = int'(a_addr[p][5:2]);
               exp_q.push_back(model[w]);
               chk("a_st_rdata", a_rdata[p], exp_q.pop_front());
               if (a_write[p]) begin
                  for (int b = 0; b < 4; b++)
                     if (a_wstrb[p][b]) model[w][b*8 +: 8] = a_wdata[p][b*8 +: 8];
               end
               chk("a_st_wait", (waitc[p] + 1 <= 4), 1);
               for (int q = 0; q < NPA; q++) if (q != p && pend[q]) waitc[q]++;
               done_now[p] = 1'b1;
               n_done++;
            end
         end
         done_prev = done_now;
         for (int p = 0; p < NPA; p++) begin
            if (!pend[p] && cyc < 2800 && $urandom_range(0, 1) == 1) begin
               pend[p]    = 1'b1;
               waitc[p]   = 0;
               a_valid[p] = 1'b1;
               a_write[p] = 1'(($urandom_range(0, 1)));
               a_addr[p]  = 30'hC00 | 30'($urandom_range(0, 15) << 2) | 30'($urandom_range(0, 3));
               a_wdata[p] = $urandom;
               a_wstrb[p] = 4'($urandom_range(0, 15));
               n_issued++;
            end
         end
      end
      @(posedge clk); #1;
      for (int p = 0; p < NPA; p++) begin
         if (done_prev[p]) begin
            pend[p] = 1'b0;
            a_valid[p] = 1'b0;
         end
      end
      chk("a_st_drain", pend, 0);
      chk("a_st_count", n_done, n_issued);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
